pic_isr_controller: RTL and testbench
=====================================

Name: pic_isr_controller

Overview:
- Parametrised, clocked successor to the 8259 in-service register.
- Holds the ISR and resolves the highest-priority unmasked request against the in-service levels, in fully nested mode.
- Supports rotating priority, specific and non-specific EOI, and auto-EOI.
- Sits between the IRR/IMR and the control/INTA sequencer; drives INT and the vector index.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; must be >= 2.
- ID_W, $clog2(NUM_IRQ), width of a level index; derived localparam, not overridable.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt_request  in  NUM_IRQ  pending requests from the IRR.
- interrupt_mask  in  NUM_IRQ  IMR; 1 = masked.
- int_ack  in  1  one-cycle INTA pulse: commit the current candidate.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific.
- eoi_level  in  ID_W  level for specific EOI.
- rotate_on_eoi  in  1  rotate priority when an ISR bit is retired.
- auto_eoi  in  1  AEOI mode: ack does not set ISR.
- int_out  out  1  registered INT request.
- int_vector  out  ID_W  registered level of the current candidate.
- in_service_register  out  NUM_IRQ  ISR contents.
- clear_irr  out  NUM_IRQ  one-hot, one-cycle pulse telling the IRR to drop the acked bit.
- spurious  out  1  one-cycle pulse when an ack arrives with int_out=0.
- lowest_priority  out  ID_W  current rotation pointer.

Behaviour:
- Reset values: ISR=0, int_out=0, int_vector=0, clear_irr=0, spurious=0, lowest_priority=NUM_IRQ-1, so IR0 has highest priority.
- Priority order: highest is (lowest_priority+1) mod NUM_IRQ, descending with wrap-around; lowest is lowest_priority.
- Candidate: the highest-priority bit of interrupt_request & ~interrupt_mask.
- Fully nested rule: int_out is asserted only if a candidate exists and it has strictly higher priority than the highest-priority set ISR bit (any candidate qualifies when ISR=0). An equal or lower level stays blocked.
- Timing: int_out and int_vector are registered, so a request or mask change is visible 1 cycle later. int_vector holds its last value while int_out=0.
- Mask changes do not alter ISR bits that are already set.
- Ack with int_out=1:
  - Next cycle, ISR[int_vector] is set, unless auto_eoi.
  - clear_irr pulses one-hot on int_vector for exactly 1 cycle.
  - With auto_eoi=1 and rotate_on_eoi=1, lowest_priority <= int_vector.
- Ack with int_out=0: ISR unchanged, clear_irr=0, spurious pulses for 1 cycle.
- Non-specific EOI:
  - Clears the highest-priority set ISR bit under the current rotation.
  - If ISR=0, no-op and no rotation.
- Specific EOI: clears ISR[eoi_level]; clearing an already-clear bit is a no-op (ISR unchanged).
- Rotation on EOI: when rotate_on_eoi=1 and a bit is actually cleared, lowest_priority <= the cleared level, taking effect the same edge.
- eoi_level >= NUM_IRQ is ignored; nothing changes.
- Simultaneous ack and EOI in one cycle:
  - The EOI is evaluated on the pre-ack ISR; the ack bit is then OR-ed in.
  - If both target the same bit, set wins.
  - Rotation from the EOI applies; int_vector was already captured before rotation.
- int_out is recomputed every cycle from the updated ISR/pointer, so it can re-assert the cycle after an EOI.
- Reset asserted mid-operation clears everything to the reset values on that edge; pending pulses are dropped.

Decomposition:
- Package pic_pkg:
  - default NUM_IRQ constant.
  - function rot_priority_first(vec, lowest_priority), returning found flag plus index.
  - function prio_higher(a, b, lowest_priority).
- One sub-module, pic_priority_resolver: combinational rotate/find-first, instantiated twice (request candidate and ISR top).

Test Plan:
- Reset, request=8'b0000_0001, mask=0 -> int_out=1, int_vector=0 after 1 cycle; ack -> ISR=8'b0000_0001, clear_irr=8'b0000_0001 for 1 cycle.
- ISR=8'b0000_0001, request=8'b0101_0000, mask=8'b0100_0000 -> int_out stays 0 (IR4 is lower than IR0); non-specific EOI -> ISR=0, next cycle int_out=1, int_vector=4.
- ISR=8'b0001_0000, request=8'b0000_0100 -> int_out=1, vector=2; ack -> ISR=8'b0001_0100; non-specific EOI clears bit 2 first, then bit 4.
- rotate_on_eoi=1, ISR bit 3 set, specific EOI level 3 -> ISR=0, lowest_priority=3; request=8'b0001_1001 -> int_vector=4.
- auto_eoi=1, rotate_on_eoi=1, request IR5 -> ack leaves ISR=0, clear_irr=8'b0010_0000, lowest_priority=5; ack while int_out=0 -> spurious=1, no state change.
- Ack and specific EOI (level 6) in the same cycle with ISR=8'b0100_0000, candidate IR1 -> ISR=8'b0000_0010; reset mid-sequence -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared constants, types and priority helpers for the PIC ISR block.
//   NUM_IRQ_DEFAULT     default number of interrupt lines
//   MAX_IRQ / MAX_ID_W  widest configuration the helper functions handle
//   eoi_cmd_t           decoded EOI command kind
//   rot_priority_first  highest-priority set bit under a rotation pointer
//   prio_higher         strict priority comparison of two levels
package pic_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;
    localparam int MAX_IRQ         = 64;
    localparam int MAX_ID_W        = $clog2(MAX_IRQ);

    typedef logic [MAX_IRQ-1:0] irq_vec_t;

    typedef enum logic [1:0] {
        EOI_NONE        = 2'd0,
        EOI_NONSPECIFIC = 2'd1,
        EOI_SPECIFIC    = 2'd2
    } eoi_cmd_t;

    // Highest priority is lowest+1 (mod n), descending with wrap-around.
    // The scan walks from the lowest-priority position up to the highest so
    // that the last hit (the highest-priority one) is the value kept.
    // The loop bound is a constant so the function unrolls cleanly; the
    // "k <= n" guard trims it to the configured width.
    function automatic logic rot_priority_first(
        input  irq_vec_t    vec,
        input  int unsigned lowest,
        input  int unsigned n,
        output int unsigned idx
    );
        logic        found;
        int unsigned pos;
        found = 1'b0;
        idx   = 0;
        for (int k = MAX_IRQ; k >= 1; k--) begin
            if (unsigned'(k) <= n) begin
                pos = lowest + unsigned'(k);
                if (pos >= n) begin
                    pos = pos - n;
                end
                if (vec[pos[MAX_ID_W-1:0]]) begin
                    found = 1'b1;
                    idx   = pos;
                end
            end
        end
        return found;
    endfunction

    // True when level a has strictly higher priority than level b.
    // Rank 0 is the highest-priority position, i.e. (lowest+1) mod n.
    function automatic logic prio_higher(
        input int unsigned a,
        input int unsigned b,
        input int unsigned lowest,
        input int unsigned n
    );
        int unsigned rank_a;
        int unsigned rank_b;
        rank_a = a + n - lowest - 1;
        if (rank_a >= n) begin
            rank_a = rank_a - n;
        end
        rank_b = b + n - lowest - 1;
        if (rank_b >= n) begin
            rank_b = rank_b - n;
        end
        return rank_a < rank_b;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational rotate/find-first.
//   vec              in   NUM_IRQ  bits to search
//   lowest_priority  in   ID_W     rotation pointer (lowest-priority level)
//   found            out  1        at least one bit of vec is set
//   index            out  ID_W     highest-priority set level (0 when !found)
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = NUM_IRQ_DEFAULT,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [ID_W-1:0]    lowest_priority,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    int unsigned idx_full;
    logic        unused_idx_bits;

    always_comb begin
        idx_full = 0;
        found    = rot_priority_first(irq_vec_t'(vec), 32'(lowest_priority),
                                      unsigned'(NUM_IRQ), idx_full);
    end

    assign index = idx_full[ID_W-1:0];

    // Upper bits of the helper's index are always zero for this width.
    assign unused_idx_bits = ^idx_full[31:ID_W];

endmodule

// File: rtl/pic_isr_controller.sv
// pic_isr_controller: clocked in-service register with fully nested
// priority resolution, rotating priority, specific/non-specific EOI and AEOI.
//   clock                in   1        system clock (rising edge)
//   reset                in   1        synchronous active-high reset
//   interrupt_request    in   NUM_IRQ  pending requests from the IRR
//   interrupt_mask       in   NUM_IRQ  IMR, 1 = masked
//   int_ack              in   1        INTA pulse: commit current candidate
//   eoi_valid            in   1        EOI command strobe
//   eoi_specific         in   1        1 = specific EOI on eoi_level
//   eoi_level            in   ID_W     level for specific EOI
//   rotate_on_eoi        in   1        rotate priority on ISR retirement
//   auto_eoi             in   1        AEOI: ack does not set ISR
//   int_out              out  1        registered INT request
//   int_vector           out  ID_W     registered candidate level
//   in_service_register  out  NUM_IRQ  ISR contents
//   clear_irr            out  NUM_IRQ  one-hot pulse for the acked bit
//   spurious             out  1        pulse on ack while int_out = 0
//   lowest_priority      out  ID_W     rotation pointer
module pic_isr_controller
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = NUM_IRQ_DEFAULT,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupt_request,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic               int_ack,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_level,
    input  logic               rotate_on_eoi,
    input  logic               auto_eoi,
    output logic               int_out,
    output logic [ID_W-1:0]    int_vector,
    output logic [NUM_IRQ-1:0] in_service_register,
    output logic [NUM_IRQ-1:0] clear_irr,
    output logic               spurious,
    output logic [ID_W-1:0]    lowest_priority
);

    if (NUM_IRQ < 2 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
        $error("pic_isr_controller: NUM_IRQ must be in [2, MAX_IRQ]");
    end

    localparam logic [ID_W-1:0] LP_RESET = ID_W'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic               int_q, int_d;
    logic [ID_W-1:0]    vec_q, vec_d;
    logic [NUM_IRQ-1:0] clr_q, clr_d;
    logic               spur_q, spur_d;
    logic [ID_W-1:0]    lp_q, lp_d;

    logic               ack_ok;
    logic               ack_spur;
    logic [NUM_IRQ-1:0] ack_onehot;
    logic [NUM_IRQ-1:0] masked_req;

    logic               isr_found;
    logic [ID_W-1:0]    isr_top;
    logic               cand_found;
    logic [ID_W-1:0]    cand_idx;

    eoi_cmd_t           eoi_cmd;
    logic               eoi_hit;
    logic [ID_W-1:0]    eoi_lvl;
    logic [NUM_IRQ-1:0] eoi_clear;
    logic [NUM_IRQ-1:0] beats_isr;

    // An ack only commits when INT was actually being driven; the level
    // committed is the registered vector the sequencer saw.
    assign ack_ok     = int_ack & int_q;
    assign ack_spur   = int_ack & ~int_q;
    assign ack_onehot = ack_ok ? (NUM_IRQ'(1) << vec_q) : '0;

    // The acked bit is still visible in the IRR during the ack cycle; drop it
    // from the search so INT does not re-raise for a request being retired.
    assign masked_req = interrupt_request & ~interrupt_mask & ~ack_onehot;

    // Top of the current (pre-update) ISR, used by non-specific EOI.
    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_top (
        .vec             (isr_q),
        .lowest_priority (lp_q),
        .found           (isr_found),
        .index           (isr_top)
    );

    // Request candidate under the pointer that will be in force next cycle.
    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_cand (
        .vec             (masked_req),
        .lowest_priority (lp_d),
        .found           (cand_found),
        .index           (cand_idx)
    );

    always_comb begin
        eoi_cmd = EOI_NONE;
        if (eoi_valid) begin
            eoi_cmd = eoi_specific ? EOI_SPECIFIC : EOI_NONSPECIFIC;
        end
    end

    // EOI acts on the pre-ack ISR; eoi_hit means a bit really was cleared.
    always_comb begin
        eoi_hit   = 1'b0;
        eoi_lvl   = '0;
        eoi_clear = '0;
        case (eoi_cmd)
            EOI_NONSPECIFIC: begin
                if (isr_found) begin
                    eoi_hit   = 1'b1;
                    eoi_lvl   = isr_top;
                    eoi_clear = NUM_IRQ'(1) << isr_top;
                end
            end
            EOI_SPECIFIC: begin
                if (int'(eoi_level) < NUM_IRQ && isr_q[eoi_level]) begin
                    eoi_hit   = 1'b1;
                    eoi_lvl   = eoi_level;
                    eoi_clear = NUM_IRQ'(1) << eoi_level;
                end
            end
            default: begin
                eoi_hit = 1'b0;
            end
        endcase
    end

    always_comb begin
        // Ack bit is OR-ed in after the EOI clear, so set wins on a collision.
        isr_d = (isr_q & ~eoi_clear) | (auto_eoi ? '0 : ack_onehot);

        // EOI rotation takes precedence over an AEOI rotation in the same cycle.
        lp_d = lp_q;
        if (ack_ok && auto_eoi && rotate_on_eoi) begin
            lp_d = vec_q;
        end
        if (eoi_hit && rotate_on_eoi) begin
            lp_d = eoi_lvl;
        end

        clr_d  = ack_onehot;
        spur_d = ack_spur;
    end

    // Fully nested: the candidate must beat every in-service level, which is
    // the same as beating the highest-priority one.
    genvar gi;
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_nest
        assign beats_isr[gi] = ~isr_d[gi] |
                               prio_higher(32'(cand_idx), unsigned'(gi),
                                           32'(lp_d), unsigned'(NUM_IRQ));
    end

    always_comb begin
        int_d = cand_found & (&beats_isr);
        vec_d = int_d ? cand_idx : vec_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            isr_q  <= '0;
            int_q  <= 1'b0;
            vec_q  <= '0;
            clr_q  <= '0;
            spur_q <= 1'b0;
            lp_q   <= LP_RESET;
        end else begin
            isr_q  <= isr_d;
            int_q  <= int_d;
            vec_q  <= vec_d;
            clr_q  <= clr_d;
            spur_q <= spur_d;
            lp_q   <= lp_d;
        end
    end

    assign int_out             = int_q;
    assign int_vector          = vec_q;
    assign in_service_register = isr_q;
    assign clear_irr           = clr_q;
    assign spurious            = spur_q;
    assign lowest_priority     = lp_q;

endmodule

// File: tb/tb_pic_isr_controller.sv
// Scoreboard bench for pic_isr_controller (NUM_IRQ = 8). The stimulus
// process pushes the hand-computed state expected after the next rising
// edge; the monitor pops and compares on the falling edge of that cycle.
module tb_pic_isr_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt_request;
    logic [7:0] interrupt_mask;
    logic       int_ack;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       rotate_on_eoi;
    logic       auto_eoi;
    logic       int_out;
    logic [2:0] int_vector;
    logic [7:0] in_service_register;
    logic [7:0] clear_irr;
    logic       spurious;
    logic [2:0] lowest_priority;

    pic_isr_controller #(.NUM_IRQ(8)) dut (
        .clock               (clock),
        .reset               (reset),
        .interrupt_request   (interrupt_request),
        .interrupt_mask      (interrupt_mask),
        .int_ack             (int_ack),
        .eoi_valid           (eoi_valid),
        .eoi_specific        (eoi_specific),
        .eoi_level           (eoi_level),
        .rotate_on_eoi       (rotate_on_eoi),
        .auto_eoi            (auto_eoi),
        .int_out             (int_out),
        .int_vector          (int_vector),
        .in_service_register (in_service_register),
        .clear_irr           (clear_irr),
        .spurious            (spurious),
        .lowest_priority     (lowest_priority)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         tag;
        string      name;
        logic       io;
        logic [2:0] iv;
        logic [7:0] isr;
        logic [7:0] cir;
        logic       sp;
        logic [2:0] lp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs after the next rising edge.
    task automatic expect_next(input string nm, input logic io, input logic [2:0] iv,
                               input logic [7:0] isr, input logic [7:0] cir,
                               input logic sp, input logic [2:0] lp);
        exp_t e;
        e.tag  = cyc + 1;
        e.name = nm;
        e.io   = io;
        e.iv   = iv;
        e.isr  = isr;
        e.cir  = cir;
        e.sp   = sp;
        e.lp   = lp;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.tag < cyc) begin
                n_miss++;
                $display("FAIL %s: sample slot missed (due cycle %0d, now %0d)", e.name, e.tag, cyc);
            end else if (int_out !== e.io || int_vector !== e.iv || in_service_register !== e.isr ||
                         clear_irr !== e.cir || spurious !== e.sp || lowest_priority !== e.lp) begin
                n_miss++;
                $display("FAIL %s: got int=%b vec=%0d isr=%08b clr=%08b spur=%b lp=%0d, expected int=%b vec=%0d isr=%08b clr=%08b spur=%b lp=%0d",
                         e.name, int_out, int_vector, in_service_register, clear_irr, spurious, lowest_priority,
                         e.io, e.iv, e.isr, e.cir, e.sp, e.lp);
            end else begin
                $display("ok   %-16s int=%b vec=%0d isr=%08b clr=%08b spur=%b lp=%0d",
                         e.name, int_out, int_vector, in_service_register, clear_irr, spurious, lowest_priority);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        interrupt_request = '0;
        interrupt_mask = '0;
        int_ack = 1'b0;
        eoi_valid = 1'b0;
        eoi_specific = 1'b0;
        eoi_level = '0;
        rotate_on_eoi = 1'b0;
        auto_eoi = 1'b0;

        expect_next("reset", 0, 0, 8'h00, 8'h00, 0, 7);
        tick();
        reset = 1'b0;

        // IR0 request and ack
        interrupt_request = 8'b0000_0001;
        expect_next("req_ir0", 1, 0, 8'h00, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        expect_next("ack_ir0", 0, 0, 8'h01, 8'h01, 0, 7);
        tick();
        int_ack = 1'b0;
        interrupt_request = '0;
        expect_next("clr_pulse_end", 0, 0, 8'h01, 8'h00, 0, 7);
        tick();

        // Lower level blocked by IR0 in service; masked IR6 ignored
        interrupt_request = 8'b0101_0000;
        interrupt_mask = 8'b0100_0000;
        expect_next("nested_block", 0, 0, 8'h01, 8'h00, 0, 7);
        tick();
        eoi_valid = 1'b1;
        eoi_specific = 1'b0;
        expect_next("ns_eoi_ir0", 1, 4, 8'h00, 8'h00, 0, 7);
        tick();
        eoi_valid = 1'b0;

        // Nesting IR2 over IR4
        int_ack = 1'b1;
        expect_next("ack_ir4", 0, 4, 8'h10, 8'h10, 0, 7);
        tick();
        int_ack = 1'b0;
        interrupt_request = 8'b0000_0100;
        interrupt_mask = '0;
        expect_next("req_ir2_nest", 1, 2, 8'h10, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        expect_next("ack_ir2", 0, 2, 8'h14, 8'h04, 0, 7);
        tick();
        int_ack = 1'b0;
        interrupt_request = '0;
        eoi_valid = 1'b1;
        eoi_specific = 1'b0;
        expect_next("ns_eoi_ir2", 0, 2, 8'h10, 8'h00, 0, 7);
        tick();
        expect_next("ns_eoi_ir4", 0, 2, 8'h00, 8'h00, 0, 7);
        tick();
        rotate_on_eoi = 1'b1;
        expect_next("ns_eoi_empty", 0, 2, 8'h00, 8'h00, 0, 7);
        tick();
        eoi_valid = 1'b0;
        rotate_on_eoi = 1'b0;

        // Specific EOI with rotation
        interrupt_request = 8'b0000_1000;
        expect_next("req_ir3", 1, 3, 8'h00, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        expect_next("ack_ir3", 0, 3, 8'h08, 8'h08, 0, 7);
        tick();
        int_ack = 1'b0;
        interrupt_request = '0;
        eoi_valid = 1'b1;
        eoi_specific = 1'b1;
        eoi_level = 3'd5;
        rotate_on_eoi = 1'b1;
        expect_next("seoi_clear_noop", 0, 3, 8'h08, 8'h00, 0, 7);
        tick();
        eoi_level = 3'd3;
        expect_next("seoi_ir3_rot", 0, 3, 8'h00, 8'h00, 0, 3);
        tick();
        eoi_valid = 1'b0;
        eoi_specific = 1'b0;
        rotate_on_eoi = 1'b0;
        interrupt_request = 8'b0001_1001;
        expect_next("rot_prio_ir4", 1, 4, 8'h00, 8'h00, 0, 3);
        tick();

        // Auto-EOI with rotation, then a spurious ack
        interrupt_request = 8'b0010_0000;
        auto_eoi = 1'b1;
        rotate_on_eoi = 1'b1;
        expect_next("req_ir5", 1, 5, 8'h00, 8'h00, 0, 3);
        tick();
        int_ack = 1'b1;
        expect_next("aeoi_ack_ir5", 0, 5, 8'h00, 8'h20, 0, 5);
        tick();
        interrupt_request = '0;
        expect_next("spurious", 0, 5, 8'h00, 8'h00, 1, 5);
        tick();
        int_ack = 1'b0;
        expect_next("spur_end", 0, 5, 8'h00, 8'h00, 0, 5);
        tick();
        auto_eoi = 1'b0;
        rotate_on_eoi = 1'b0;

        // Back to default priority, then ack + specific EOI in one cycle
        reset = 1'b1;
        expect_next("reset2", 0, 0, 8'h00, 8'h00, 0, 7);
        tick();
        reset = 1'b0;
        interrupt_request = 8'b0100_0000;
        expect_next("req_ir6", 1, 6, 8'h00, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        expect_next("ack_ir6", 0, 6, 8'h40, 8'h40, 0, 7);
        tick();
        int_ack = 1'b0;
        interrupt_request = 8'b0000_0010;
        expect_next("req_ir1_nest", 1, 1, 8'h40, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        eoi_valid = 1'b1;
        eoi_specific = 1'b1;
        eoi_level = 3'd6;
        expect_next("ack_eoi_same", 0, 1, 8'h02, 8'h02, 0, 7);
        tick();
        int_ack = 1'b0;
        eoi_valid = 1'b0;
        eoi_specific = 1'b0;
        interrupt_request = '0;
        interrupt_mask = 8'b0000_0010;
        expect_next("mask_keeps_isr", 0, 1, 8'h02, 8'h00, 0, 7);
        tick();

        // Reset in the middle of an ack
        interrupt_mask = '0;
        interrupt_request = 8'b0000_0001;
        expect_next("req_ir0_nest", 1, 0, 8'h02, 8'h00, 0, 7);
        tick();
        int_ack = 1'b1;
        reset = 1'b1;
        expect_next("reset_mid", 0, 0, 8'h00, 8'h00, 0, 7);
        tick();
        int_ack = 1'b0;
        reset = 1'b0;
        interrupt_request = '0;
        expect_next("post_reset", 0, 0, 8'h00, 8'h00, 0, 7);
        tick();

        // Drain: anything still queued after the bound is a miss.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            tick();
        end
        while (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: never sampled (queue drain timeout)", sb[0].name);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
